// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register-file geometry and ALU op encodings
// used by the register file, ALU and control decoder.
package mips_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NREG     = 2 ** ADDR_W;
  localparam int unsigned ZERO_REG = 0;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

endpackage

// File: rtl/mips_regfile_read_port.sv
// One read port of the register file: r0 forced to zero, then write-first
// bypass of the in-flight writeback, else the stored register.
module rf_read_port
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0]                  addr,
  input  logic                               we,
  input  logic [ADDR_W-1:0]                  wa,
  input  logic [DATA_W-1:0]                  wd,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]   regs,
  output logic [DATA_W-1:0]                  value
);

  always_comb begin
    value = regs[addr];
    if (addr == ADDR_W'(ZERO_REG)) begin
      value = '0;
    end else if (we && (wa == addr)) begin
      value = wd;
    end
  end

endmodule

// File: rtl/mips_regfile.sv
// MIPS integer register file: two registered read ports with write-first
// bypass, one write port, r0 hardwired to zero.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rd_valid
);

  localparam int unsigned NREG_L = 2 ** ADDR_W;

  logic [NREG_L-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DATA_W-1:0]             rd1_q, rd1_d;
  logic [DATA_W-1:0]             rd2_q, rd2_d;
  logic                          rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]             val1, val2;

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port1 (
    .addr  (ra1),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .regs  (regs_q),
    .value (val1)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port2 (
    .addr  (ra2),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .regs  (regs_q),
    .value (val2)
  );

  always_comb begin
    regs_d = regs_q;
    if (we && (wa != ADDR_W'(ZERO_REG))) begin
      regs_d[wa] = wd;
    end
  end

  always_comb begin
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    rd_valid_d = 1'b0;
    if (re) begin
      rd1_d      = val1;
      rd2_d      = val2;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q     <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd1      = rd1_q;
  assign rd2      = rd2_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_mips_regfile.sv
// Directed self-checking bench for mips_regfile.
module tb_mips_regfile;
  import mips_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              re;
  logic [ADDR_W-1:0] ra1, ra2;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] rd1, rd2;
  logic              rd_valid;

  int checks   = 0;
  int failures = 0;

  mips_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .re       (re),
    .ra1      (ra1),
    .ra2      (ra2),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .rd1      (rd1),
    .rd2      (rd2),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DATA_W-1:0] alu(input alu_op_t op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    case (op)
      ALU_AND: alu = a & b;
      ALU_OR:  alu = a | b;
      ALU_ADD: alu = a + b;
      ALU_SUB: alu = a - b;
      ALU_SLT: alu = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
      default: alu = '0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; wa = '0; wd = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); ra1 = '0; ra2 = '0;
    step();
    checks++;
    if (rd1 !== '0 || rd2 !== '0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_init: rd1=%h rd2=%h rd_valid=%b, want 0 0 0", rd1, rd2, rd_valid);
    end
    rst = 1'b0;
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    step();
    we = 1'b0; re = 1'b1; ra1 = 5'd5; ra2 = 5'd5;
    step();
    checks++;
    if (rd1 !== 32'hDEADBEEF || rd2 !== 32'hDEADBEEF || rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_prefill: rd1=%h rd2=%h rd_valid=%b, want deadbeef deadbeef 1", rd1, rd2, rd_valid);
    end
    // read and write in flight when reset asserts mid-cycle
    we = 1'b1; wa = 5'd6; wd = 32'h55AA55AA;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rd1 !== '0 || rd2 !== '0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: rd1=%h rd2=%h rd_valid=%b, want 0 0 0", rd1, rd2, rd_valid);
    end
    step();
    checks++;
    if (rd_valid !== 1'b0 || rd1 !== '0) begin
      failures++;
      $display("FAIL reset_held: rd1=%h rd_valid=%b, want 0 0", rd1, rd_valid);
    end
    rst = 1'b0; we = 1'b0; re = 1'b1; ra1 = 5'd5; ra2 = 5'd6;
    step();
    checks++;
    if (rd1 !== '0 || rd2 !== '0 || rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_cleared: rd1=%h rd2=%h rd_valid=%b, want 0 0 1", rd1, rd2, rd_valid);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; re = 1'b0;
    step();
    we = 1'b0; re = 1'b1; ra1 = 5'd0; ra2 = 5'd0;
    step();
    checks++;
    if (rd1 !== '0 || rd2 !== '0) begin
      failures++;
      $display("FAIL zero_reg: rd1=%h rd2=%h, want 0 0", rd1, rd2);
    end
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; re = 1'b1; ra1 = 5'd0;
    step();
    checks++;
    if (rd1 !== '0) begin
      failures++;
      $display("FAIL zero_bypass: rd1=%h, want 0", rd1);
    end
    idle();
  endtask

  task automatic test_basic_alu();
    logic [DATA_W-1:0] x;
    we = 1'b1; wa = 5'd1; wd = 32'd4;
    step();
    wa = 5'd2; wd = 32'd1;
    step();
    we = 1'b0; re = 1'b1; ra1 = 5'd1; ra2 = 5'd2;
    step();
    checks++;
    if (rd1 !== 32'd4 || rd2 !== 32'd1 || rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_read: rd1=%h rd2=%h rd_valid=%b, want 4 1 1", rd1, rd2, rd_valid);
    end
    x = alu(ALU_SUB, rd1, rd2);
    checks++;
    if (x !== 32'd3 || (x == '0)) begin
      failures++;
      $display("FAIL alu_sub: x=%h zero=%b, want 3 0", x, (x == '0));
    end
    idle();
  endtask

  task automatic test_bypass_hold();
    we = 1'b1; wa = 5'd7; wd = 32'h12345678; re = 1'b1; ra1 = 5'd7; ra2 = 5'd7;
    step();
    checks++;
    if (rd1 !== 32'h12345678 || rd2 !== 32'h12345678) begin
      failures++;
      $display("FAIL bypass: rd1=%h rd2=%h, want 12345678 12345678", rd1, rd2);
    end
    we = 1'b0; re = 1'b1; ra1 = 5'd2; ra2 = 5'd2;
    step();
    re = 1'b1; ra1 = 5'd7; ra2 = 5'd7;
    step();
    checks++;
    if (rd1 !== 32'h12345678 || rd2 !== 32'h12345678) begin
      failures++;
      $display("FAIL bypass_stored: rd1=%h rd2=%h, want 12345678 12345678", rd1, rd2);
    end
    re = 1'b0; ra1 = 5'd1; ra2 = 5'd2;
    step();
    checks++;
    if (rd1 !== 32'h12345678 || rd2 !== 32'h12345678 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_re0: rd1=%h rd2=%h rd_valid=%b, want 12345678 12345678 0", rd1, rd2, rd_valid);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    we = 1'b1; wa = 5'd3; wd = 32'hA; re = 1'b0;
    step();
    wd = 32'hB; re = 1'b1; ra1 = 5'd3; ra2 = 5'd1;
    step();
    checks++;
    if (rd1 !== 32'hB || rd2 !== 32'd4) begin
      failures++;
      $display("FAIL b2b_bypass: rd1=%h rd2=%h, want b 4", rd1, rd2);
    end
    we = 1'b0; re = 1'b1; ra1 = 5'd3; ra2 = 5'd3;
    step();
    checks++;
    if (rd1 !== 32'hB || rd2 !== 32'hB || rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_stored: rd1=%h rd2=%h rd_valid=%b, want b b 1", rd1, rd2, rd_valid);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_basic_alu();
    test_bypass_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_regfile.md
Name: mips_regfile

Overview:
- MIPS integer register file directly upstream of the ALU.
- Two registered read ports drive the ALU a/b operands; one write port takes the writeback result.
- Register 0 is hardwired to zero.
- Same-cycle write-to-read bypass, so a value written in cycle N appears on rd1/rd2 in cycle N+1.

Parameters:
DATA_W, 32, register and data width in bits
ADDR_W, 5, register address width; register count NREG = 2**ADDR_W (32)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  asynchronous reset, active-high
re  input  1  read enable; captures both read ports this cycle
ra1  input  ADDR_W  read address, port 1 (rs)
ra2  input  ADDR_W  read address, port 2 (rt)
we  input  1  write enable
wa  input  ADDR_W  write address (rd/rt)
wd  input  DATA_W  write data
rd1  output  DATA_W  registered read data, port 1; feeds ALU a
rd2  output  DATA_W  registered read data, port 2; feeds ALU b
rd_valid  output  1  high the cycle after an accepted read

Behaviour:
- Reset (asynchronous assert, any time):
  - all NREG registers = 0
  - rd1 = 0, rd2 = 0, rd_valid = 0
  - takes effect immediately, not at the next edge
  - a write or read in flight when rst asserts is discarded
  - deassertion is synchronised externally; the first edge with rst low is a normal cycle
- Write, at posedge with rst low:
  - if we=1 and wa!=0, then reg[wa] <= wd
  - we=1 with wa=0 is ignored; reg[0] stays 0
- Read, at posedge with rst low and re=1 (latency 1 cycle):
  - rd1 <= value(ra1), rd2 <= value(ra2), rd_valid <= 1
  - value(a) = 0 if a==0
  - else value(a) = wd if we=1 and wa==a (write-first bypass)
  - else value(a) = reg[a]
- re=0: rd1/rd2 hold their last values; rd_valid <= 0.
- ra1==ra2 is legal; both ports return the same value, including under bypass.
- Simultaneous write to the same address on consecutive cycles: the last write wins, and reads reflect the newest write (bypass covers the in-cycle one).
- No combinational path from inputs to outputs; all outputs come straight from flops.
- Arithmetic: none. Addresses are fully decoded; the address width equals the register count width, so there is no out-of-range case.

Decomposition:
- Shared package (mips_pkg): DATA_W, ADDR_W, NREG, ZERO_REG = 0. The ALU op encodings (AND=000, OR=001, ADD=010, SUB=110, SLT=111) also move here so the register file, ALU and control decoder share one source.
- One sub-module: rf_read_port. It takes an address, the write-port signals and the register array view, and returns value(a) as defined above (zero check plus bypass mux). It is instantiated twice.
- Storage array and output flops stay in mips_regfile.

Test Plan:
- Reset clears: assert rst mid-run after writing reg[5]=0xDEADBEEF; then read ra1=5, ra2=5 -> rd1=rd2=0; rd_valid=0 while rst is high.
- Zero register: we=1, wa=0, wd=0xFFFFFFFF; next cycle re=1, ra1=0 -> rd1=0.
- Basic write/read feeding the ALU:
  - write reg[1]=4, then reg[2]=1
  - read ra1=1, ra2=2 -> next cycle rd1=4, rd2=1, rd_valid=1
  - with the ALU op=SUB, x=3 and zero=0
- Bypass: same cycle we=1, wa=7, wd=0x12345678, re=1, ra1=7, ra2=7 -> next cycle rd1=rd2=0x12345678; a later read of 7 returns the same value.
- Hold on re=0: after the read above, drive re=0 and change ra1 to 1 -> rd1 stays 0x12345678 and rd_valid drops to 0.
- Back-to-back overwrite: write reg[3]=0xA then reg[3]=0xB on consecutive cycles, with re=1, ra1=3 on the second cycle -> rd1=0xB.
